// File: rtl/data_memory_access.sv
`default_nettype none
// ============================================================================
// data_memory_access : load/store stage on an internal little-endian byte
//                      memory with fixed access latency and fault detection
// Revision 1.0
// ============================================================================
module data_memory_access #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic        resp_valid,
  output logic [63:0] read_data,
  output logic        resp_mem_read,
  output logic        access_fault,
  output logic        busy
);
  localparam int              C_AW       = $clog2(MEM_BYTES);
  localparam int              C_CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [C_CW-1:0] C_CNT_INIT = C_CW'(LATENCY - 1);
  localparam logic [64:0]     C_MEM_END  = 65'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic              ld_q, ld_d, st_q, st_d, skip_q, skip_d, flt_q, flt_d;
  logic [2:0]        f3_q, f3_d;
  logic [C_AW-1:0]   addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [63:0]       read_data_q, read_data_d;
  logic              resp_mem_read_q, resp_mem_read_d, access_fault_q, access_fault_d;
  logic              busy_q, busy_d;

  logic [7:0]        mem [MEM_BYTES];

  logic [3:0]  req_size, req_size_m1;
  logic        is_store, is_noop, misaligned, out_of_range, illegal, req_fault;
  logic [3:0]  acc_size;
  logic [63:0] raw, load_ext;
  logic        access_edge;

  always_comb begin
    req_size     = 4'd1 << funct3[1:0];
    req_size_m1  = req_size - 4'd1;
    is_store     = !mem_read && mem_write;
    is_noop      = !mem_read && !mem_write;
    misaligned   = |(address[2:0] & req_size_m1[2:0]);
    // 65-bit sum so addresses near 2^64 cannot wrap into range
    out_of_range = ({1'b0, address} + {61'd0, req_size}) > C_MEM_END;
    illegal      = (funct3 == 3'b111) || (is_store && funct3[2]);
    req_fault    = !is_noop && (illegal || misaligned || out_of_range);
  end

  always_comb begin
    acc_size = 4'd1 << f3_q[1:0];
    raw      = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < acc_size) raw[8*i +: 8] = mem[addr_q + C_AW'(i)];
    end
    case (f3_q)
      3'b000:  load_ext = {{56{raw[7]}},  raw[7:0]};
      3'b001:  load_ext = {{48{raw[15]}}, raw[15:0]};
      3'b010:  load_ext = {{32{raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
    access_edge = (state_q == ACCESS) && (cnt_q == '0);
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ld_d            = ld_q;
    st_d            = st_q;
    skip_d          = skip_q;
    flt_d           = flt_q;
    f3_d            = f3_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    resp_valid_d    = 1'b0;
    read_data_d     = read_data_q;
    resp_mem_read_d = resp_mem_read_q;
    access_fault_d  = access_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ld_d    = mem_read;
          st_d    = is_store;
          f3_d    = funct3;
          addr_d  = address[C_AW-1:0];
          wdata_d = write_data;
          flt_d   = req_fault;
          // no-ops and faults spend a single cycle waiting and touch no memory
          skip_d  = is_noop || req_fault;
          cnt_d   = (is_noop || req_fault) ? '0 : C_CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d         = RESP;
          resp_valid_d    = 1'b1;
          resp_mem_read_d = ld_q;
          access_fault_d  = flt_q;
          read_data_d     = (ld_q && !skip_q) ? load_ext : 64'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ld_q            <= 1'b0;
      st_q            <= 1'b0;
      skip_q          <= 1'b0;
      flt_q           <= 1'b0;
      f3_q            <= 3'd0;
      addr_q          <= '0;
      wdata_q         <= 64'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      read_data_q     <= 64'd0;
      resp_mem_read_q <= 1'b0;
      access_fault_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ld_q            <= ld_d;
      st_q            <= st_d;
      skip_q          <= skip_d;
      flt_q           <= flt_d;
      f3_q            <= f3_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      read_data_q     <= read_data_d;
      resp_mem_read_q <= resp_mem_read_d;
      access_fault_q  <= access_fault_d;
      busy_q          <= busy_d;
    end
  end

  // Reset forces state_q to IDLE, so an aborted store never reaches this edge
  always_ff @(posedge clk) begin
    if (access_edge && st_q && !skip_q) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < acc_size) mem[addr_q + C_AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign read_data     = read_data_q;
  assign resp_mem_read = resp_mem_read_q;
  assign access_fault  = access_fault_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_access.sv
`default_nettype none
// ============================================================================
// tb_data_memory_access : directed vector table, reset-abort sequence and
//                         random traffic against a byte-array reference model
// Revision 1.0
// ============================================================================
module tb_data_memory_access;
  localparam int MEM_BYTES = 1024;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] address = 64'd0, write_data = 64'd0;
  logic        req_ready, resp_valid, resp_mem_read, access_fault, busy;
  logic [63:0] read_data;

  data_memory_access #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .address(address), .write_data(write_data), .resp_valid(resp_valid),
    .read_data(read_data), .resp_mem_read(resp_mem_read),
    .access_fault(access_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] ref_mem [MEM_BYTES];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp_data;
    logic        exp_mr;
    logic        exp_flt;
    int          exp_lat;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: spec rules over a plain byte array
  task automatic ref_model(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd,
                           output logic [63:0] data, output logic mr,
                           output logic flt, output int lat);
    logic        noop, st;
    int          size;
    logic [63:0] v;
    size = 1 << f3[1:0];
    noop = !rd && !wr;
    st   = !rd && wr;
    flt  = !noop && ((f3 == 3'b111) || (st && f3[2]) || ((a % 64'(size)) != 0) ||
                     (a >= 64'(MEM_BYTES)) || (a + 64'(size) > 64'(MEM_BYTES)));
    mr   = rd;
    lat  = (noop || flt) ? 1 : LATENCY;
    data = 64'd0;
    if (!flt && rd) begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
      data = v;
    end
    if (!flt && st) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rdata, output logic mr,
                        output logic flt, output int lat);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_req", {63'd0, req_ready}, 64'd1);
    mem_read = rd; mem_write = wr; funct3 = f3; address = a; write_data = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    rdata = read_data;
    mr    = resp_mem_read;
    flt   = access_fault;
    @(posedge clk);
    #1;
    check("resp_one_cycle", {63'd0, resp_valid}, 64'd0);
    check("ready_after_resp", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic run_cmp(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] e_data, input logic e_mr, input logic e_flt,
                         input int e_lat);
    logic [63:0] d;
    logic        mr, flt;
    int          lat;
    do_req(rd, wr, f3, a, wd, d, mr, flt, lat);
    check({tag, "_data"},  d, e_data);
    check({tag, "_mr"},    {63'd0, mr}, {63'd0, e_mr});
    check({tag, "_fault"}, {63'd0, flt}, {63'd0, e_flt});
    check({tag, "_lat"},   64'(lat), 64'(e_lat));
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] ed, input logic emr, input logic ef,
                              input int el);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd;
    v.exp_data = ed; v.exp_mr = emr; v.exp_flt = ef; v.exp_lat = el;
    return v;
  endfunction

  initial begin
    logic [63:0] md;
    logic        mmr, mflt;
    int          mlat;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [63:0] a, wd;
    int          sel, size;

    vecs[0]  = mk(0, 1, 3'b011, 64'h10, 64'h8877665544332211, 64'd0, 0, 0, LATENCY);
    vecs[1]  = mk(1, 0, 3'b011, 64'h10, 64'd0, 64'h8877665544332211, 1, 0, LATENCY);
    vecs[2]  = mk(1, 0, 3'b000, 64'h17, 64'd0, 64'hFFFFFFFFFFFFFF88, 1, 0, LATENCY);
    vecs[3]  = mk(1, 0, 3'b100, 64'h17, 64'd0, 64'h0000000000000088, 1, 0, LATENCY);
    vecs[4]  = mk(1, 0, 3'b001, 64'h16, 64'd0, 64'hFFFFFFFFFFFF8877, 1, 0, LATENCY);
    vecs[5]  = mk(1, 0, 3'b110, 64'h14, 64'd0, 64'h0000000088776655, 1, 0, LATENCY);
    vecs[6]  = mk(0, 1, 3'b000, 64'h11, 64'hAA, 64'd0, 0, 0, LATENCY);
    vecs[7]  = mk(1, 0, 3'b011, 64'h10, 64'd0, 64'h887766554433AA11, 1, 0, LATENCY);
    vecs[8]  = mk(1, 0, 3'b011, 64'h13, 64'd0, 64'd0, 1, 1, 1);
    vecs[9]  = mk(0, 1, 3'b010, 64'(MEM_BYTES - 2), 64'hFFFFFFFF, 64'd0, 0, 1, 1);
    vecs[10] = mk(1, 0, 3'b111, 64'h10, 64'd0, 64'd0, 1, 1, 1);
    vecs[11] = mk(0, 1, 3'b111, 64'h10, 64'h5555, 64'd0, 0, 1, 1);
    vecs[12] = mk(1, 0, 3'b011, 64'h10, 64'd0, 64'h887766554433AA11, 1, 0, LATENCY);
    vecs[13] = mk(1, 1, 3'b011, 64'h10, 64'h0, 64'h887766554433AA11, 1, 0, LATENCY);
    vecs[14] = mk(1, 0, 3'b011, 64'h10, 64'd0, 64'h887766554433AA11, 1, 0, LATENCY);
    vecs[15] = mk(0, 0, 3'b011, 64'h10, 64'hFF, 64'd0, 0, 0, 1);
    vecs[16] = mk(0, 1, 3'b011, 64'h20, 64'h00000000DEADBEEF, 64'd0, 0, 0, LATENCY);
    vecs[17] = mk(1, 0, 3'b011, 64'(MEM_BYTES - 8), 64'd0, 64'd0, 1, 0, LATENCY);

    // asynchronous reset, checked before any clock edge releases it
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready",  {63'd0, req_ready}, 64'd1);
    check("rst_valid",  {63'd0, resp_valid}, 64'd0);
    check("rst_data",   read_data, 64'd0);
    check("rst_mr",     {63'd0, resp_mem_read}, 64'd0);
    check("rst_fault",  {63'd0, access_fault}, 64'd0);
    check("rst_busy",   {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // bring the memory to a known all-zero image
    for (int i = 0; i < MEM_BYTES; i += 8) begin
      ref_model(0, 1, 3'b011, 64'(i), 64'd0, md, mmr, mflt, mlat);
      do_req(0, 1, 3'b011, 64'(i), 64'd0, md, mmr, mflt, mlat);
    end

    for (int i = 0; i < 18; i++) begin
      ref_model(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, md, mmr, mflt, mlat);
      run_cmp($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
              vecs[i].wd, vecs[i].exp_data, vecs[i].exp_mr, vecs[i].exp_flt, vecs[i].exp_lat);
    end

    // reset on the edge before the store would commit
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b011;
    address = 64'h20; write_data = 64'h1234; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ready", {63'd0, req_ready}, 64'd1);
    check("abort_valid", {63'd0, resp_valid}, 64'd0);
    check("abort_data",  read_data, 64'd0);
    check("abort_mr",    {63'd0, resp_mem_read}, 64'd0);
    check("abort_fault", {63'd0, access_fault}, 64'd0);
    check("abort_busy",  {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("abort_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    ref_model(1, 0, 3'b011, 64'h20, 64'd0, md, mmr, mflt, mlat);
    run_cmp("abort_old", 1, 0, 3'b011, 64'h20, 64'd0, 64'h00000000DEADBEEF, 1, 0, LATENCY);

    // random traffic concentrated on a small window for read-after-write hits
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 7));
      rd  = (sel >= 1 && sel <= 3) || sel == 7;
      wr  = (sel >= 4);
      f3  = 3'($urandom_range(0, 7));
      size = 1 << f3[1:0];
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 64'($urandom_range(0, 127)) & ~64'(size - 1);
      else if (sel == 7) a = 64'($urandom_range(0, 127));
      else if (sel == 8) a = 64'(MEM_BYTES - 8 + int'($urandom_range(0, 7)));
      else               a = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      ref_model(rd, wr, f3, a, wd, md, mmr, mflt, mlat);
      run_cmp($sformatf("rnd%0d", n), rd, wr, f3, a, wd, md, mmr, mflt, mlat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
